// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
// Holds the op encoding and the op field width.
package pc_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD = 3'd0;
    localparam logic [OP_W-1:0] OP_INC  = 3'd1;
    localparam logic [OP_W-1:0] OP_JMP  = 3'd2;
    localparam logic [OP_W-1:0] OP_BRA  = 3'd3;
    localparam logic [OP_W-1:0] OP_CALL = 3'd4;
    localparam logic [OP_W-1:0] OP_RET  = 3'd5;

endpackage

// File: rtl/pc_stack.sv
// LIFO of return addresses with a 0..DEPTH count register.
// The top entry is read combinationally.
module pc_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] r_count;
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign w_wr_idx  = AW'(r_count);
    assign w_rd_idx  = AW'(r_count - CW'(1));

    // Read index is only meaningful when the stack holds an entry.
    assign dout = empty ? '0 : r_mem[w_rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + CW'(1);
        end else if (w_do_pop) begin
            r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with step, jump, relative branch,
// call/return stack and sticky overflow/underflow flags.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int             W         = 8,
    parameter int             STEP      = 1,
    parameter int             DEPTH     = 4,
    parameter logic [W-1:0]   RESET_VEC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    target,
    input  logic [W-1:0]    offset,
    input  logic            err_clr,
    output logic [W-1:0]    pc,
    output logic            stk_full,
    output logic            stk_empty,
    output logic            err_ovf,
    output logic            err_unf
);

    localparam logic [W-1:0] STEP_W = W'(STEP);

    logic [W-1:0] r_pc;
    logic         r_err_ovf;
    logic         r_err_unf;

    logic [W-1:0] w_pc_nxt;
    logic [W-1:0] w_pc_inc;
    logic [W-1:0] w_pc_bra;
    logic [W-1:0] w_stk_dout;
    logic         w_is_inc;
    logic         w_is_jmp;
    logic         w_is_bra;
    logic         w_is_call;
    logic         w_is_ret;
    logic         w_push;
    logic         w_pop;
    logic         w_set_ovf;
    logic         w_set_unf;

    assign w_is_inc  = (op == OP_INC);
    assign w_is_jmp  = (op == OP_JMP);
    assign w_is_bra  = (op == OP_BRA);
    assign w_is_call = (op == OP_CALL);
    assign w_is_ret  = (op == OP_RET);

    // Two's-complement add gives the signed branch for free.
    assign w_pc_inc = r_pc + STEP_W;
    assign w_pc_bra = r_pc + offset;

    assign w_push    = en && w_is_call && !stk_full;
    assign w_pop     = en && w_is_ret && !stk_empty;
    assign w_set_ovf = en && w_is_call && stk_full;
    assign w_set_unf = en && w_is_ret && stk_empty;

    always_comb begin
        w_pc_nxt = r_pc;
        unique case (1'b1)
            w_is_inc:  w_pc_nxt = w_pc_inc;
            w_is_jmp:  w_pc_nxt = target;
            w_is_bra:  w_pc_nxt = w_pc_bra;
            w_is_call: w_pc_nxt = stk_full ? w_pc_inc : target;
            w_is_ret:  w_pc_nxt = stk_empty ? w_pc_inc : w_stk_dout;
            default:   w_pc_nxt = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_VEC;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            if (en) begin
                r_pc <= w_pc_nxt;
            end
            r_err_ovf <= w_set_ovf || (r_err_ovf && !err_clr);
            r_err_unf <= w_set_unf || (r_err_unf && !err_clr);
        end
    end

    pc_stack #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .dout  (w_stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign pc      = r_pc;
    assign err_ovf = r_err_ovf;
    assign err_unf = r_err_unf;

endmodule
